sp_ram_access_ctrl: RTL and testbench
=====================================

Name: sp_ram_access_ctrl

Overview:
Synchronous request/response sequencer that sits directly upstream of the 8x16 asynchronous single-port RAM (s_p_8_16_ram) and drives it.
- Converts single-cycle valid/ready requests into properly timed we/re/addr strobes.
- Owns the bidirectional data bus: drives it on writes, releases it to high-Z on reads.
- Captures read data and returns a one-cycle response pulse.
- Generates the RAM's reset pulse after system reset.

Parameters:
ADDR_W, 3, RAM address width (depth = 2**ADDR_W)
DATA_W, 16, RAM data width
WR_CYC, 1, cycles ram_we is held per write (must be >= 1)
RD_CYC, 1, cycles ram_re is held before read data is sampled (must be >= 1)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request this cycle
req_wr  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  request address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  DATA_W  read data (valid when rsp_valid is high after a read)
rsp_err  out  1  verify mismatch flag, qualified by rsp_valid
ram_rst  out  1  RAM reset
ram_we  out  1  RAM write enable
ram_re  out  1  RAM read enable
ram_addr  out  ADDR_W  RAM address
ram_data  inout  DATA_W  RAM data bus

Behaviour:
- Single clock domain. Reset is synchronous and active-high; clock port is clk and reset port is rst.
- Reset values: state=RST, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, ram_we=0, ram_re=0, ram_addr=0, ram_data=high-Z, ram_rst=1.
- States:
  - RST: ram_rst=1, req_ready=0. Held while rst=1 and for 2 cycles after rst falls, then IDLE.
  - IDLE: req_ready=1.
    - On req_valid&&req_ready, latch req_wr, req_addr and req_wdata.
    - Go to WR if req_wr=1, else RD.
  - WR: ram_we=1, ram_re=0, ram_addr=latched address, ram_data driven with latched wdata. Lasts WR_CYC cycles, then TURN.
  - RD: ram_re=1, ram_we=0, ram_data high-Z. Lasts RD_CYC cycles. On the clock edge ending the last RD cycle, capture ram_data into rsp_rdata. Then TURN.
  - TURN: ram_we=0, ram_re=0, bus high-Z, rsp_valid=1 for exactly this cycle, req_ready=0. Then IDLE.
- Latency: request accepted at edge T.
  - Write: strobes in cycles T+1..T+WR_CYC; rsp_valid in cycle T+WR_CYC+1; req_ready high again at T+WR_CYC+2.
  - Read: same timing with RD_CYC in place of WR_CYC.
- Invariants:
  - ram_we and ram_re are never both 1.
  - ram_data is driven only in WR.
  - There is at least one TURN cycle (bus high-Z, no strobes) between any two accesses.
- ram_addr holds its last value in IDLE and TURN. All RAM-side outputs are registered (glitch-free).
- rsp_rdata holds its last read value across writes and idle cycles. Writes leave it unchanged.
- req_valid without req_ready: ignored, no latch. The requester holds the request.
- A write followed immediately by a read of the same address returns the new data.
- Reset mid-operation: at the next edge with rst=1, return to RST, drop all strobes, release the bus, and suppress rsp_valid. The in-flight request is lost.
- Back-to-back throughput: one access per WR_CYC+2 (or RD_CYC+2) cycles.

Optional Feature:
WR_VERIFY_EN
- Defined: each write is followed by an automatic read-back: WR -> TURN(no rsp) -> RD(same addr, RD_CYC) -> TURN(rsp).
  - rsp_rdata = read-back value.
  - rsp_err = 1 if read-back != written data, else 0.
  - Write latency becomes WR_CYC+RD_CYC+2 cycles to rsp_valid.
  - Reads are unchanged, with rsp_err=0.
- Undefined: rsp_err is tied to 0 and write timing is as above.

Test Plan:
- Reset: hold rst=1 for 3 cycles, then release -> ram_rst=1 through 2 cycles after release, then req_ready=1; all strobes 0 and bus high-Z throughout.
- Write/read sequence: write 16'h0001@1, 16'h0002@2, 16'h0003@3, then read 1, 2, 3 -> rsp_rdata 16'h0001, 16'h0002, 16'h0003. Each rsp_valid arrives WR_CYC+1 / RD_CYC+1 cycles after acceptance.
- Bus discipline: random back-to-back mix of 50 requests -> assertions never fire: we&&re, bus driven outside WR, or missing TURN gap. Scoreboard matches every read.
- Stall: req_valid=1 while req_ready=0 during TURN -> no duplicate access; the request is accepted exactly once in the following IDLE.
- Reset mid-write: assert rst in cycle T+1 of a write of 16'hBEEF@5 -> no rsp_valid, strobes low next edge, req_ready=0 until RST completes.
- WR_VERIFY_EN defined: write 16'hA5A5@7 -> rsp_valid after WR_CYC+RD_CYC+2 cycles with rsp_rdata=16'hA5A5 and rsp_err=0. Force a RAM data-bit fault -> rsp_err=1.

Source files
------------

// File: rtl/sp_ram_access_ctrl.sv
// Valid/ready sequencer driving an async single-port RAM with registered strobes and a shared data bus.
// Optional macro WR_VERIFY_EN: every write is followed by an automatic read-back and compare.
module sp_ram_access_ctrl #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16,
  parameter int WR_CYC = 1,
  parameter int RD_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              ram_rst,
  output logic              ram_we,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data
);

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    ST_RST,
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_TURN
  } state_e;

  state_e              state_q;
  logic [1:0]          rst_cnt_q;
  logic [CNT_W-1:0]    cyc_q;
  logic                req_ready_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                ram_rst_q;
  logic                ram_we_q;
  logic                ram_re_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic                drive_q;
  logic [DATA_W-1:0]   wdata_q;
`ifdef WR_VERIFY_EN
  logic                verify_q;
  logic                chk_q;
  logic                rsp_err_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RST;
      rst_cnt_q   <= '0;
      cyc_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      ram_rst_q   <= 1'b1;
      ram_we_q    <= 1'b0;
      ram_re_q    <= 1'b0;
      ram_addr_q  <= '0;
      drive_q     <= 1'b0;
      wdata_q     <= '0;
`ifdef WR_VERIFY_EN
      verify_q    <= 1'b0;
      chk_q       <= 1'b0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_RST: begin
          // Two cycles of RAM reset after rst is released.
          if (rst_cnt_q == 2'd1) begin
            state_q     <= ST_IDLE;
            ram_rst_q   <= 1'b0;
            req_ready_q <= 1'b1;
          end else begin
            rst_cnt_q <= rst_cnt_q + 2'd1;
          end
        end
        ST_IDLE: begin
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            ram_addr_q  <= req_addr;
            cyc_q       <= '0;
            if (req_wr) begin
              state_q  <= ST_WR;
              ram_we_q <= 1'b1;
              drive_q  <= 1'b1;
              wdata_q  <= req_wdata;
`ifdef WR_VERIFY_EN
              verify_q <= 1'b1;
`endif
            end else begin
              state_q  <= ST_RD;
              ram_re_q <= 1'b1;
`ifdef WR_VERIFY_EN
              chk_q    <= 1'b0;
`endif
            end
          end
        end
        ST_WR: begin
          if (cyc_q == CNT_W'(WR_CYC - 1)) begin
            state_q  <= ST_TURN;
            ram_we_q <= 1'b0;
            drive_q  <= 1'b0;
`ifndef WR_VERIFY_EN
            rsp_valid_q <= 1'b1;
`endif
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        ST_RD: begin
          if (cyc_q == CNT_W'(RD_CYC - 1)) begin
            state_q     <= ST_TURN;
            ram_re_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= ram_data;
`ifdef WR_VERIFY_EN
            rsp_err_q   <= chk_q && (ram_data != wdata_q);
            chk_q       <= 1'b0;
`endif
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        ST_TURN: begin
`ifdef WR_VERIFY_EN
          // A write's silent turnaround leads into the read-back of the same address.
          if (verify_q) begin
            verify_q <= 1'b0;
            chk_q    <= 1'b1;
            state_q  <= ST_RD;
            ram_re_q <= 1'b1;
            cyc_q    <= '0;
          end else begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
          end
`else
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
`endif
        end
        default: begin
          state_q   <= ST_RST;
          rst_cnt_q <= '0;
          ram_rst_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign ram_rst   = ram_rst_q;
  assign ram_we    = ram_we_q;
  assign ram_re    = ram_re_q;
  assign ram_addr  = ram_addr_q;
  assign ram_data  = drive_q ? wdata_q : {DATA_W{1'bz}};
`ifdef WR_VERIFY_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_sp_ram_access_ctrl.sv
// Directed bench for sp_ram_access_ctrl with a behavioural 8x16 RAM on a pulled-up bus.
// Compile with WR_VERIFY_EN defined to exercise the write read-back feature.
module tb_sp_ram_access_ctrl;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 16;
  localparam int WR_CYC = 2;
  localparam int RD_CYC = 1;
`ifdef WR_VERIFY_EN
  localparam int WR_LAT = WR_CYC + RD_CYC + 2;
  localparam int WR_ACC = 2;
`else
  localparam int WR_LAT = WR_CYC + 1;
  localparam int WR_ACC = 1;
`endif
  localparam int RD_LAT = RD_CYC + 1;
  localparam logic [DATA_W-1:0] BUS_IDLE = {DATA_W{1'b1}};

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              ram_rst;
  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;
  tri1  [DATA_W-1:0] ram_data;

  logic [DATA_W-1:0] ram_mem   [8];
  logic [DATA_W-1:0] model_mem [8];
  logic [DATA_W-1:0] fault_mask = '0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] last_rd;
  int checks   = 0;
  int failures = 0;

  logic prev_we = 1'b0;
  logic prev_re = 1'b0;
  int   we_run  = 0;
  int   re_run  = 0;
  int   access_cnt = 0;

  always #5 clk = ~clk;

  sp_ram_access_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WR_CYC(WR_CYC), .RD_CYC(RD_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_rst(ram_rst), .ram_we(ram_we), .ram_re(ram_re),
    .ram_addr(ram_addr), .ram_data(ram_data)
  );

  // Behavioural RAM: fault_mask flips read bits to emulate a stuck data line.
  assign ram_data = (ram_re && !ram_we) ? (ram_mem[ram_addr] ^ fault_mask) : {DATA_W{1'bz}};

  always @(posedge clk) begin
    if (ram_rst) begin
      for (int i = 0; i < 8; i++) ram_mem[i] <= '0;
    end else if (ram_we) begin
      ram_mem[ram_addr] <= ram_data;
    end
  end

  // Strobe history as seen during the previous cycle.
  always @(posedge clk) begin
    prev_we <= ram_we;
    prev_re <= ram_re;
    we_run  <= ram_we ? we_run + 1 : 0;
    re_run  <= ram_re ? re_run + 1 : 0;
    if ((ram_we || ram_re) && !(prev_we || prev_re)) access_cnt <= access_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic txn(input logic wr, input logic [ADDR_W-1:0] addr,
                     input logic [DATA_W-1:0] wdata, input bit chained, input string tag);
    int waits;
    int lat;
    int exp_lat;
    int acc0;
    logic [DATA_W-1:0] exp_rd;
    logic exp_err;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    waits = 0;
    while (!req_ready && waits < 10) begin
      @(negedge clk);
      waits++;
    end
    checks++;
    if (waits != (chained ? 1 : 0)) begin
      failures++;
      $display("FAIL %s_accept_wait got=%0d exp=%0d", tag, waits, chained ? 1 : 0);
    end
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    acc0 = access_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    if (wr) begin
      model_mem[addr] = wdata;
      exp_lat = WR_LAT;
    end else begin
      exp_q.push_back(model_mem[addr] ^ fault_mask);
      exp_lat = RD_LAT;
    end
    lat = 0;
    for (int n = 1; n <= 12 && lat == 0; n++) begin
      @(negedge clk);
      checks++;
      if (ram_we && ram_re) begin
        failures++;
        $display("FAIL %s_we_and_re cycle=%0d", tag, n);
      end else if (!ram_we && ram_data !== BUS_IDLE && !ram_re) begin
        failures++;
        $display("FAIL %s_bus_driven got=%h exp=%h cycle=%0d", tag, ram_data, BUS_IDLE, n);
      end else if ((ram_we && prev_re) || (ram_re && prev_we)) begin
        failures++;
        $display("FAIL %s_turn_gap cycle=%0d", tag, n);
      end else if ((ram_we && we_run >= WR_CYC) || (ram_re && re_run >= RD_CYC)) begin
        failures++;
        $display("FAIL %s_strobe_len we_run=%0d re_run=%0d", tag, we_run, re_run);
      end
      if (n == 1) begin
        checks++;
        if ({ram_we, ram_re, ram_addr} !== {wr, !wr, addr} ||
            (wr && ram_data !== wdata)) begin
          failures++;
          $display("FAIL %s_first_strobe got=%b%b@%0d bus=%h exp=%b%b@%0d bus=%h",
                   tag, ram_we, ram_re, ram_addr, ram_data, wr, !wr, addr, wdata);
        end
      end
      if (rsp_valid) lat = n;
    end
    checks++;
    if (lat != exp_lat) begin
      failures++;
      $display("FAIL %s_latency got=%0d exp=%0d", tag, lat, exp_lat);
    end
    if (wr) begin
`ifdef WR_VERIFY_EN
      exp_rd  = wdata ^ fault_mask;
      exp_err = (fault_mask != '0);
`else
      exp_rd  = last_rd;
      exp_err = 1'b0;
`endif
    end else begin
      exp_rd  = exp_q.pop_front();
      exp_err = 1'b0;
    end
    last_rd = exp_rd;
    if (lat != 0) begin
      checks++;
      if (rsp_rdata !== exp_rd) begin
        failures++;
        $display("FAIL %s_rdata got=%h exp=%h", tag, rsp_rdata, exp_rd);
      end
      checks++;
      if (rsp_err !== exp_err) begin
        failures++;
        $display("FAIL %s_err got=%b exp=%b", tag, rsp_err, exp_err);
      end
      checks++;
      if (access_cnt - acc0 != (wr ? WR_ACC : 1)) begin
        failures++;
        $display("FAIL %s_access_count got=%0d exp=%0d", tag, access_cnt - acc0, wr ? WR_ACC : 1);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({req_ready, rsp_valid, rsp_err, ram_we, ram_re, ram_rst} !== 6'b000001 ||
          rsp_rdata !== '0 || ram_addr !== '0 || ram_data !== BUS_IDLE) begin
        failures++;
        $display("FAIL reset_hold got rdy=%b vld=%b err=%b we=%b re=%b rrst=%b rd=%h a=%0d bus=%h exp 0 0 0 0 0 1 0 0 %h",
                 req_ready, rsp_valid, rsp_err, ram_we, ram_re, ram_rst, rsp_rdata, ram_addr, ram_data, BUS_IDLE);
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== (n == 2) || ram_rst !== (n != 2) || ram_we !== 1'b0 ||
          ram_re !== 1'b0 || ram_data !== BUS_IDLE || rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_release_%0d got rdy=%b rrst=%b we=%b re=%b bus=%h vld=%b exp rdy=%b rrst=%b",
                 n, req_ready, ram_rst, ram_we, ram_re, ram_data, rsp_valid, n == 2, n != 2);
      end
    end
    for (int i = 0; i < 8; i++) model_mem[i] = '0;
    last_rd = '0;
  endtask

  task automatic test_write_read();
    txn(1'b1, 3'd1, 16'h0001, 1'b0, "wr1");
    txn(1'b1, 3'd2, 16'h0002, 1'b1, "wr2");
    txn(1'b1, 3'd3, 16'h0003, 1'b1, "wr3");
    txn(1'b0, 3'd1, 16'h0000, 1'b1, "rd1");
    txn(1'b0, 3'd2, 16'h0000, 1'b1, "rd2");
    txn(1'b0, 3'd3, 16'h0000, 1'b1, "rd3");
  endtask

  task automatic test_back_to_back();
    txn(1'b1, 3'd6, 16'h5A5A, 1'b1, "b2b_wr");
    txn(1'b0, 3'd6, 16'h0000, 1'b1, "b2b_rd");
    txn(1'b1, 3'd0, 16'h8001, 1'b1, "b2b_wr0");
    txn(1'b1, 3'd7, 16'h7FFE, 1'b1, "b2b_wr7");
    txn(1'b0, 3'd0, 16'h0000, 1'b1, "b2b_rd0");
    txn(1'b0, 3'd7, 16'h0000, 1'b1, "b2b_rd7");
  endtask

  task automatic test_stall();
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL stall_turn got rdy=%b vld=%b exp rdy=0 vld=1", req_ready, rsp_valid);
    end
    txn(1'b0, 3'd2, 16'h0000, 1'b1, "stall_rd");
    txn(1'b1, 3'd2, 16'h1234, 1'b1, "stall_wr");
    txn(1'b0, 3'd2, 16'h0000, 1'b1, "stall_rd2");
  endtask

  task automatic test_random();
    for (int i = 0; i < 50; i++) begin
      txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
          16'($urandom_range(0, 16'hFFFE)), 1'b1, "rand");
    end
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 3'd5;
    req_wdata = 16'hBEEF;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_ready got=%b exp=1", req_ready);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ram_we !== 1'b1 || ram_addr !== 3'd5) begin
      failures++;
      $display("FAIL midrst_write_started got we=%b a=%0d exp we=1 a=5", ram_we, ram_addr);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || ram_we !== 1'b0 || ram_re !== 1'b0 ||
          ram_data !== BUS_IDLE || req_ready !== (n == 2) || ram_rst !== (n != 2)) begin
        failures++;
        $display("FAIL midrst_%0d got vld=%b we=%b re=%b bus=%h rdy=%b rrst=%b exp vld=0 we=0 re=0 rdy=%b rrst=%b",
                 n, rsp_valid, ram_we, ram_re, ram_data, req_ready, ram_rst, n == 2, n != 2);
      end
    end
    for (int i = 0; i < 8; i++) model_mem[i] = '0;
    last_rd = '0;
    checks++;
    if (rsp_rdata !== '0) begin
      failures++;
      $display("FAIL midrst_rdata got=%h exp=0000", rsp_rdata);
    end
    txn(1'b0, 3'd5, 16'h0000, 1'b0, "midrst_rd5");
  endtask

`ifdef WR_VERIFY_EN
  task automatic test_verify();
    txn(1'b1, 3'd7, 16'hA5A5, 1'b1, "verify_ok");
    fault_mask = 16'h0001;
    txn(1'b1, 3'd7, 16'hA5A5, 1'b1, "verify_fault");
    fault_mask = '0;
    txn(1'b0, 3'd7, 16'h0000, 1'b1, "verify_rd");
  endtask
`endif

  initial begin
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    last_rd   = '0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_stall();
    test_random();
`ifdef WR_VERIFY_EN
    test_verify();
`endif
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
